// File: rtl/mp_pkg.sv
// -----------------------------------------------------------------------------
// mp_pkg
// Items shared by the modular-exponentiation controller and the Montgomery
// product stage:
//   - opcodes sent to the product stage on mp_op_code
//       OPXX : square the running result            (X * X)
//       OPXM : multiply the running result by base  (X * M)
//       OPX1 : leave the Montgomery domain          (X * 1)
//   - the controller state encoding
//   - helpers that map an issue state to its opcode
// -----------------------------------------------------------------------------
package mp_pkg;

  localparam logic [1:0] OPXX = 2'd0;
  localparam logic [1:0] OPXM = 2'd1;
  localparam logic [1:0] OPX1 = 2'd2;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    SCAN       = 4'd1,
    SQR_ISSUE  = 4'd2,
    SQR_WAIT   = 4'd3,
    MUL_ISSUE  = 4'd4,
    MUL_WAIT   = 4'd5,
    CONV_ISSUE = 4'd6,
    CONV_WAIT  = 4'd7,
    DONE       = 4'd8
  } mexp_state_t;

  // True for the three states that launch a product.
  function automatic logic is_issue(input mexp_state_t s);
    return (s == SQR_ISSUE) || (s == MUL_ISSUE) || (s == CONV_ISSUE);
  endfunction

  // Opcode launched by an issue state. Any other state maps to OPX1, but the
  // result is only used when is_issue() holds.
  function automatic logic [1:0] issue_op(input mexp_state_t s);
    logic [1:0] op;
    case (s)
      SQR_ISSUE: op = OPXX;
      MUL_ISSUE: op = OPXM;
      default:   op = OPX1;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/msb_find.sv
// -----------------------------------------------------------------------------
// msb_find
// Combinational most-significant-one finder for the exponent register.
//
// Parameters
//   EBITS : width of the searched vector
//   IW    : width of the returned index
// Ports
//   vec   : in  [EBITS-1:0] vector to search
//   idx   : out [IW-1:0]    position of the highest set bit (0 if none)
//   found : out             at least one bit of vec is set
// -----------------------------------------------------------------------------
module msb_find #(
  parameter int EBITS = 1024,
  parameter int IW    = (EBITS > 1) ? $clog2(EBITS) : 1
) (
  input  logic [EBITS-1:0] vec,
  output logic [IW-1:0]    idx,
  output logic             found
);

  // Ascending scan: the last set bit visited is the most significant one, so
  // later iterations simply overwrite earlier hits.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < EBITS; i++) begin
      if (vec[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_exp_ctrl.sv
// -----------------------------------------------------------------------------
// mod_exp_ctrl
// Sequencer for left-to-right binary modular exponentiation on top of a
// Montgomery product stage. For each exponent bit, from the top down, it
// issues a square (OPXX) and, when the bit is 1, a multiply (OPXM). A final
// OPX1 converts the result out of the Montgomery domain.
//
// Parameters
//   EBITS : exponent width in bits
//   CNTW  : width of the per-product iteration count
// Ports
//   clk        : in   clock, rising edge
//   rst_n      : in   asynchronous active-low reset
//   go         : in   start request, only looked at while idle
//   exponent   : in   [EBITS-1:0] exponent, captured when go is accepted
//   mp_cnt_cfg : in   [CNTW-1:0]  iteration count, captured when go is accepted
//   mp_start   : out  one-cycle start pulse to the product stage
//   mp_op_code : out  [1:0] operation for the product stage
//   mp_count   : out  [CNTW-1:0] captured iteration count
//   mp_stop    : in   product stage completion level (rising edge = done)
//   busy       : out  run in progress
//   done       : out  one-cycle pulse when the final conversion has finished
//   op_total   : out  [11:0] products issued in the current or last run
//
// Build option
//   SKIP_LEADING_ZEROS_EN : when defined, the scan jumps straight to the
//   highest set exponent bit (via msb_find) and an all-zero exponent goes
//   directly to the conversion. When undefined, every bit from EBITS-1 down
//   is squared, leading zeros included.
// -----------------------------------------------------------------------------
module mod_exp_ctrl
  import mp_pkg::*;
#(
  parameter int EBITS = 1024,
  parameter int CNTW  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [EBITS-1:0] exponent,
  input  logic [CNTW-1:0]  mp_cnt_cfg,
  output logic             mp_start,
  output logic [1:0]       mp_op_code,
  output logic [CNTW-1:0]  mp_count,
  input  logic             mp_stop,
  output logic             busy,
  output logic             done,
  output logic [11:0]      op_total
);

  localparam int            IW      = (EBITS > 1) ? $clog2(EBITS) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(EBITS - 1);

  mexp_state_t      state;
  mexp_state_t      next_state;

  logic [EBITS-1:0] exp_q;
  logic [IW-1:0]    bit_idx;
  logic [CNTW-1:0]  count_q;
  logic [11:0]      total_q;
  logic [1:0]       op_q;
  logic             stop_q;

  logic             stop_rise;
  logic             cur_bit;
  logic             idx_zero;

  logic             accept_go;
  logic             dec_idx;
  logic             issue;

`ifdef SKIP_LEADING_ZEROS_EN
  logic [IW-1:0]    msb_idx;
  logic             msb_found;
  logic             load_msb;

  msb_find #(
    .EBITS (EBITS),
    .IW    (IW)
  ) u_msb_find (
    .vec   (exp_q),
    .idx   (msb_idx),
    .found (msb_found)
  );
`endif

  // Completion is the rising edge of mp_stop only; a level that is already
  // high when a wait state is entered belongs to the previous product.
  assign stop_rise = mp_stop & ~stop_q;
  assign cur_bit   = exp_q[bit_idx];
  assign idx_zero  = (bit_idx == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the per-cycle datapath strobes.
  always_comb begin
    next_state = state;
    accept_go  = 1'b0;
    dec_idx    = 1'b0;
    issue      = 1'b0;
`ifdef SKIP_LEADING_ZEROS_EN
    load_msb   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (go) begin
          accept_go  = 1'b1;
          next_state = SCAN;
        end
      end

      SCAN: begin
`ifdef SKIP_LEADING_ZEROS_EN
        if (msb_found) begin
          load_msb   = 1'b1;
          next_state = SQR_ISSUE;
        end else begin
          next_state = CONV_ISSUE;
        end
`else
        next_state = SQR_ISSUE;
`endif
      end

      SQR_ISSUE: begin
        issue      = 1'b1;
        next_state = SQR_WAIT;
      end

      SQR_WAIT: begin
        if (stop_rise) begin
          if (cur_bit) begin
            next_state = MUL_ISSUE;
          end else if (!idx_zero) begin
            dec_idx    = 1'b1;
            next_state = SQR_ISSUE;
          end else begin
            next_state = CONV_ISSUE;
          end
        end
      end

      MUL_ISSUE: begin
        issue      = 1'b1;
        next_state = MUL_WAIT;
      end

      MUL_WAIT: begin
        if (stop_rise) begin
          if (!idx_zero) begin
            dec_idx    = 1'b1;
            next_state = SQR_ISSUE;
          end else begin
            next_state = CONV_ISSUE;
          end
        end
      end

      CONV_ISSUE: begin
        issue      = 1'b1;
        next_state = CONV_WAIT;
      end

      CONV_WAIT: begin
        if (stop_rise) begin
          next_state = DONE;
        end
      end

      DONE: begin
        next_state = IDLE;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Run context: exponent, iteration count and bit index. These only change
  // on go acceptance and during the scan, so input changes mid-run are
  // ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q   <= '0;
      count_q <= '0;
      bit_idx <= '0;
    end else begin
      if (accept_go) begin
        exp_q   <= exponent;
        count_q <= mp_cnt_cfg;
        bit_idx <= TOP_IDX;
`ifdef SKIP_LEADING_ZEROS_EN
      end else if (load_msb) begin
        bit_idx <= msb_idx;
`endif
      end else if (dec_idx) begin
        bit_idx <= bit_idx - 1'b1;
      end
    end
  end

  // Opcode is loaded on the way into an issue state so it is valid alongside
  // mp_start, then held through the wait until the next issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= OPXX;
    end else if (is_issue(next_state)) begin
      op_q <= issue_op(next_state);
    end
  end

  // Product counter: cleared on acceptance, bumped once per issue, and left
  // alone after the run so the last total stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
    end else if (accept_go) begin
      total_q <= '0;
    end else if (issue) begin
      total_q <= total_q + 12'd1;
    end
  end

  // Delayed copy of mp_stop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop_q <= 1'b0;
    end else begin
      stop_q <= mp_stop;
    end
  end

  // Outputs decode directly from the state so reset clears them at once.
  assign mp_start   = is_issue(state);
  assign mp_op_code = op_q;
  assign mp_count   = count_q;
  assign op_total   = total_q;
  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mod_exp_ctrl
// Self-checking bench for mod_exp_ctrl with EBITS=8. A product-stage model
// answers each mp_start with mp_stop dropping and rising again after a fixed
// latency, optionally holding mp_stop high for a while first. Expected
// opcode sequences come from plain left-to-right binary exponentiation.
// Build option SKIP_LEADING_ZEROS_EN selects the matching expectations.
// -----------------------------------------------------------------------------
module tb_mod_exp_ctrl;
  import mp_pkg::*;

  localparam int EBITS = 8;
  localparam int CNTW  = 6;
  localparam int LAT   = 5;
`ifdef SKIP_LEADING_ZEROS_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic             clk        = 1'b0;
  logic             rst_n      = 1'b0;
  logic             go         = 1'b0;
  logic [EBITS-1:0] exponent   = '0;
  logic [CNTW-1:0]  mp_cnt_cfg = '0;
  logic             mp_stop    = 1'b1;
  logic             mp_start;
  logic [1:0]       mp_op_code;
  logic [CNTW-1:0]  mp_count;
  logic             busy;
  logic             done;
  logic [11:0]      op_total;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mod_exp_ctrl #(
    .EBITS (EBITS),
    .CNTW  (CNTW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .exponent   (exponent),
    .mp_cnt_cfg (mp_cnt_cfg),
    .mp_start   (mp_start),
    .mp_op_code (mp_op_code),
    .mp_count   (mp_count),
    .mp_stop    (mp_stop),
    .busy       (busy),
    .done       (done),
    .op_total   (op_total)
  );

  // Product-stage model, evaluated on the falling edge away from DUT updates.
  logic [1:0] obs_q[$];
  logic [1:0] ref_ops[$];
  int         hold_cycles = 0;
  bit         pm_active   = 1'b0;
  bit         prev_start  = 1'b0;
  int         pm_k        = 0;
  logic [1:0] pm_op       = 2'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pm_active  = 1'b0;
      pm_k       = 0;
      mp_stop    = 1'b1;
      prev_start = 1'b0;
    end else begin
      if (mp_start) begin
        n_cmp++;
        if (prev_start || pm_active) begin
          n_fail++;
          $display("[TB] FAIL start_isolated: mp_start with prev_start=%0b product_busy=%0b, required both 0",
                   prev_start, pm_active);
        end
        obs_q.push_back(mp_op_code);
        pm_op     = mp_op_code;
        pm_active = 1'b1;
        pm_k      = 0;
      end else if (pm_active) begin
        pm_k++;
        n_cmp++;
        if (mp_op_code !== pm_op) begin
          n_fail++;
          $display("[TB] FAIL op_stable: mp_op_code=%0d during product, required %0d", mp_op_code, pm_op);
        end
        if (pm_k > hold_cycles) begin
          if (pm_k < hold_cycles + LAT) begin
            mp_stop = 1'b0;
          end else begin
            mp_stop   = 1'b1;
            pm_active = 1'b0;
          end
        end
      end
      prev_start = mp_start;
    end
  end

  // Reference: square per scanned bit, multiply on 1 bits, then convert.
  task automatic build_expected(input logic [EBITS-1:0] e);
    int top;
    ref_ops.delete();
    top = EBITS - 1;
    if (SKIP) begin
      top = -1;
      for (int i = 0; i < EBITS; i++) if (e[i]) top = i;
    end
    for (int i = top; i >= 0; i--) begin
      ref_ops.push_back(OPXX);
      if (e[i]) ref_ops.push_back(OPXM);
    end
    ref_ops.push_back(OPX1);
  endtask

  // One complete run with checks on busy, done, op sequence, op_total and
  // mp_count. With disturb set, go is pulsed and inputs change mid-run.
  task automatic run_exp(input string name, input logic [EBITS-1:0] e,
                         input logic [CNTW-1:0] cfg, input int hold, input bit disturb);
    int dones = 0;
    bit seen  = 1'b0;
    int cyc   = 0;
    build_expected(e);
    obs_q.delete();
    hold_cycles = hold;
    @(negedge clk);
    go = 1'b1; exponent = e; mp_cnt_cfg = cfg;
    @(negedge clk);
    go = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL %s_busy_start: busy=%0b, required 1", name, busy);
    end
    while (!seen && cyc < 3000) begin
      if (disturb && cyc == 6) begin
        go = 1'b1; exponent = ~e; mp_cnt_cfg = ~cfg;
      end
      if (disturb && cyc == 7) go = 1'b0;
      @(negedge clk);
      cyc++;
      if (disturb && cyc == 9) begin
        n_cmp++;
        if (mp_count !== cfg) begin
          n_fail++;
          $display("[TB] FAIL %s_count_midrun: mp_count=%0d, required %0d", name, mp_count, cfg);
        end
      end
      if (done) begin
        seen = 1'b1;
        dones++;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("[TB] FAIL %s_timeout: done not seen in 3000 cycles, required a done pulse", name);
    end else begin
      if (busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL %s_busy_at_done: busy=%0b, required 0", name, busy);
      end
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (done) dones++;
      end
      n_cmp++;
      if (dones != 1) begin
        n_fail++;
        $display("[TB] FAIL %s_done_pulses: saw %0d, required 1", name, dones);
      end
    end
    n_cmp++;
    if (op_total !== 12'(ref_ops.size())) begin
      n_fail++;
      $display("[TB] FAIL %s_op_total: op_total=%0d, required %0d", name, op_total, ref_ops.size());
    end
    n_cmp++;
    if (obs_q.size() != ref_ops.size()) begin
      n_fail++;
      $display("[TB] FAIL %s_op_count: issued %0d ops, required %0d", name, obs_q.size(), ref_ops.size());
    end
    for (int i = 0; i < ref_ops.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== ref_ops[i]) begin
        n_fail++;
        $display("[TB] FAIL %s_op[%0d]: opcode=%0d, required %0d", name, i, obs_q[i], ref_ops[i]);
      end
    end
    n_cmp++;
    if (mp_count !== cfg) begin
      n_fail++;
      $display("[TB] FAIL %s_mp_count: mp_count=%0d, required %0d", name, mp_count, cfg);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mp_start, mp_op_code, mp_count, busy, done, op_total} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: start=%0b op=%0d count=%0d busy=%0b done=%0b total=%0d, required all 0",
               mp_start, mp_op_code, mp_count, busy, done, op_total);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || mp_start !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: busy=%0b start=%0b, required 0 0", busy, mp_start);
    end
  endtask

  task automatic test_known_vectors();
    run_exp("exp_101", 8'b0000_0101, 6'd17, 0, 1'b0);
    n_cmp++;
    if (op_total !== (SKIP ? 12'd6 : 12'd11)) begin
      n_fail++;
      $display("[TB] FAIL exp_101_total_const: op_total=%0d, required %0d", op_total, SKIP ? 6 : 11);
    end
    run_exp("exp_zero", 8'h00, 6'd3, 0, 1'b0);
    n_cmp++;
    if (op_total !== (SKIP ? 12'd1 : 12'd9)) begin
      n_fail++;
      $display("[TB] FAIL exp_zero_total_const: op_total=%0d, required %0d", op_total, SKIP ? 1 : 9);
    end
  endtask

  task automatic test_stop_held();
    run_exp("stop_held", 8'b0010_1101, 6'd9, 4, 1'b0);
  endtask

  task automatic test_go_while_busy();
    run_exp("go_busy", 8'b1001_0011, 6'd21, 0, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    bit hit = 1'b0;
    hold_cycles = 0;
    @(negedge clk);
    go = 1'b1; exponent = 8'b0110_0110; mp_cnt_cfg = 6'd5;
    @(negedge clk);
    go = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(negedge clk);
      if (mp_start && mp_op_code == OPXM) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin
      n_fail++;
      $display("[TB] FAIL midrst_find_mul: no OPXM issue within 500 cycles, required one");
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mp_start, mp_op_code, mp_count, busy, done, op_total} !== '0) begin
      n_fail++;
      $display("[TB] FAIL midrst_outputs: start=%0b op=%0d count=%0d busy=%0b done=%0b total=%0d, required all 0",
               mp_start, mp_op_code, mp_count, busy, done, op_total);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_exp("ff_after_reset", 8'hFF, 6'd33, 0, 1'b0);
    n_cmp++;
    if (op_total !== 12'd17) begin
      n_fail++;
      $display("[TB] FAIL ff_total_const: op_total=%0d, required 17", op_total);
    end
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    int n1;
    build_expected(8'b0000_0011);
    n1 = ref_ops.size();
    obs_q.delete();
    hold_cycles = 0;
    @(negedge clk);
    go = 1'b1; exponent = 8'b0000_0011; mp_cnt_cfg = 6'd7;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("[TB] FAIL b2b_timeout: first done not seen, required a done pulse");
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || op_total !== 12'(n1)) begin
      n_fail++;
      $display("[TB] FAIL b2b_gap: busy=%0b total=%0d, required 0 and %0d", busy, op_total, n1);
    end
    @(negedge clk);
    go = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || op_total !== 12'd0) begin
      n_fail++;
      $display("[TB] FAIL b2b_restart: busy=%0b total=%0d, required 1 and 0", busy, op_total);
    end
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    @(negedge clk);
    n_cmp++;
    if (!seen || op_total !== 12'(n1) || obs_q.size() != 2 * n1) begin
      n_fail++;
      $display("[TB] FAIL b2b_second: seen=%0b total=%0d ops=%0d, required 1, %0d, %0d",
               seen, op_total, obs_q.size(), n1, 2 * n1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_exp($sformatf("rand%0d", i), 8'($urandom), 6'($urandom),
              int'($urandom_range(0, 2)), 1'b0);
    end
  endtask

  initial begin
    $display("[TB] start, SKIP_LEADING_ZEROS_EN=%0b", SKIP);
    test_reset();
    test_known_vectors();
    test_stop_held();
    test_go_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_exp_ctrl.md
MOD_EXP_CTRL -- requirements
Module: mod_exp_ctrl

Interface
REQ-001 SHALL have parameter EBITS, default 1024, giving the exponent width in bits.
REQ-002 SHALL have parameter CNTW, default 10, giving the width of mp_count and mp_cnt_cfg.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port go, input, 1 bit: request a new exponentiation; sampled only in IDLE.
REQ-006 SHALL have port exponent, input, EBITS bits: exponent, latched when go is accepted.
REQ-007 SHALL have port mp_cnt_cfg, input, CNTW bits: iteration count per Montgomery product, latched when go is accepted.
REQ-008 SHALL have port mp_start, output, 1 bit: one-cycle start pulse to the Montgomery product stage.
REQ-009 SHALL have port mp_op_code, output, 2 bits: operation to the product stage (OPXX=0, OPXM=1, OPX1=2).
REQ-010 SHALL have port mp_count, output, CNTW bits: the latched mp_cnt_cfg value.
REQ-011 SHALL have port mp_stop, input, 1 bit: product-stage completion level; low after start is accepted, high when the result is stored.
REQ-012 SHALL have port busy, output, 1 bit: high from go acceptance until done.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when the final conversion completes.
REQ-014 SHALL have port op_total, output, 12 bits: number of products issued in the current or last run.

Function
REQ-015 SHALL use states IDLE, SCAN, SQR_ISSUE, SQR_WAIT, MUL_ISSUE, MUL_WAIT, CONV_ISSUE, CONV_WAIT, DONE.
REQ-016 SHALL, in IDLE with go=1, latch exponent and mp_cnt_cfg, set the bit index to EBITS-1, clear op_total, assert busy, and go to SCAN.
REQ-017 SHALL, in SCAN, go to SQR_ISSUE at the current bit index, or to CONV_ISSUE if no bits remain (see REQ-028).
REQ-018 SHALL, in each *_ISSUE state, drive mp_start=1 for exactly one cycle with the matching mp_op_code (SQR=OPXX, MUL=OPXM, CONV=OPX1), increment op_total, and enter the matching *_WAIT state.
REQ-019 SHALL detect completion in *_WAIT only on a rising edge of mp_stop, using a registered copy of mp_stop; a level already high at entry SHALL NOT count as completion.
REQ-020 SHALL, on SQR_WAIT completion, go to MUL_ISSUE if the current exponent bit is 1; otherwise it SHALL decrement the bit index.
REQ-021 SHALL, on MUL_WAIT completion, or on SQR_WAIT completion with a 0 bit, go to SQR_ISSUE if the index was above 0, else to CONV_ISSUE.
REQ-022 SHALL, on CONV_WAIT completion, go to DONE; DONE SHALL pulse done for one cycle, deassert busy, and return to IDLE.
REQ-023 SHALL hold mp_op_code stable from ISSUE until the completion edge.
REQ-024 SHALL ignore go while busy; exponent and mp_cnt_cfg changes during a run SHALL have no effect.
REQ-025 SHALL make the done pulse and a simultaneous new go mutually exclusive: go is sampled only in IDLE, so it is accepted at the earliest one cycle after done.
REQ-026 SHALL hold op_total at its final value until the next go is accepted.

Reset
REQ-027 SHALL, when rst_n is low at any time including mid-run, immediately force state=IDLE, mp_start=0, mp_op_code=0, mp_count=0, busy=0, done=0, op_total=0, bit index=0, and the registered mp_stop=0.

Configuration
REQ-028 SHALL support macro SKIP_LEADING_ZEROS_EN: when defined, SCAN SHALL set the bit index to the most-significant 1 of the exponent in one cycle, and an all-zero exponent SHALL go straight to CONV_ISSUE; when undefined, SCAN SHALL start at bit EBITS-1 and square for every bit, including leading zeros.

Structure
REQ-029 SHALL take OPXX/OPXM/OPX1 and the state encodings from shared package mp_pkg, which the product stage also uses.
REQ-030 SHALL place the most-significant-one finder in sub-module msb_find (EBITS in, index plus found flag out); it is instantiated only under SKIP_LEADING_ZEROS_EN.

Verification
REQ-031 SHALL cover EBITS=8, exponent=8'b00000101, SKIP on, with a product-stage model of 5-cycle latency: op sequence XX,XM,XX,XX,XM,X1, op_total=6, one done pulse.
REQ-032 SHALL cover the same stimulus with SKIP off: five leading XX, then XX,XM,XX,XX,XM,X1, op_total=11.
REQ-033 SHALL cover exponent=0: with SKIP on, single X1 and op_total=1; with SKIP off, 8×XX then X1 and op_total=9.
REQ-034 SHALL cover mp_stop held high from before go: no op is advanced until the model drops and re-raises mp_stop, with mp_start exactly one cycle wide each time.
REQ-035 SHALL cover rst_n low during MUL_WAIT: all outputs at reset values the same cycle, then a new go with exponent=8'hFF gives op_total=17.
REQ-036 SHALL cover go pulsed while busy, and mp_cnt_cfg changed mid-run: no restart, and mp_count keeps its latched value.
